// File: rtl/imem_loader.sv
// Writable instruction store filled from a valid/ready byte stream, with a combinational fetch port.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the payload.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic [31:0]           PC,
    output logic [31:0]           instr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [32:0] CAPACITY = 33'(DEPTH);
    localparam int          BC_W     = ADDR_WIDTH + 1;
    localparam logic [31:0] BC_MAX   = 32'((64'd1 << BC_W) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CSUM;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t       state;
    state_t       next_state;
    logic [7:0]   mem [DEPTH];
    logic [15:0]  length;
    logic [15:0]  count;
    logic         err_q;
    logic         xfer;
    logic         start_load;
    logic         last_byte;
    logic         in_range;
    logic         wr_en;
    logic [32:0]  wr_addr;
    logic [31:0]  count_ext;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]   csum;
`endif

    assign xfer      = in_valid && in_ready;
    assign wr_addr   = 33'(BASE_ADDR) + 33'(count);
    assign in_range  = wr_addr < CAPACITY;
    assign last_byte = (17'(count) + 17'd1) == 17'(length);
    assign wr_en     = !rst && (state == DATA) && xfer && in_range;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_load = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    next_state = LEN_HI;
                    start_load = 1'b1;
                end
            end
            LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid)
                    next_state = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid)
                    next_state = ({length[15:8], in_data} == 16'd0) ? PAYLOAD_END : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_byte)
                    next_state = PAYLOAD_END;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid)
                    next_state = DONE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // An internal 16-bit counter tracks progress so long loads still terminate after byte_count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            length <= 16'd0;
            count  <= 16'd0;
            err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum   <= 8'd0;
`endif
        end else begin
            if (start_load) begin
                count <= 16'd0;
                err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum  <= 8'd0;
`endif
            end
            if (state == LEN_HI && xfer)
                length[15:8] <= in_data;
            if (state == LEN_LO && xfer)
                length[7:0] <= in_data;
            if (state == DATA && xfer) begin
                count <= count + 16'd1;
                if (!in_range)
                    err_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum <= csum ^ in_data;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state == CSUM && xfer && in_data != csum)
                err_q <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr[ADDR_WIDTH-1:0]] <= in_data;
    end

    assign err       = err_q;
    assign count_ext = 32'(count);
    assign byte_count = (count_ext > BC_MAX) ? BC_MAX[BC_W-1:0] : count_ext[BC_W-1:0];

    // Word-aligned big-endian fetch; PC bits above the array and the byte offset are ignored.
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  unused_pc_bits;

    assign rd_addr        = {PC[ADDR_WIDTH-1:2], 2'b00};
    assign unused_pc_bits = ^{PC[31:ADDR_WIDTH], PC[1:0]};
    assign instr = {mem[rd_addr],
                    mem[rd_addr | ADDR_WIDTH'(1)],
                    mem[rd_addr | ADDR_WIDTH'(2)],
                    mem[rd_addr | ADDR_WIDTH'(3)]};

endmodule
